// File: rtl/axis_accumulator_frame_controller.sv
// Frame/rate sequencer in front of the multichannel accumulator.
// Optional `AXIS_ACC_CTRL_INTEG_COUNT_EN adds a 32-bit integ_count output.
module axis_accumulator_frame_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1024,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [RATE_WIDTH-1:0] cfg_rate,
  input  logic                  cfg_update,
  output logic                  cfg_error,
  output logic [RATE_WIDTH-1:0] rate,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  integ_done,
  output logic                  busy
`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
  ,
  output logic [31:0]           integ_count
`endif
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [RATE_WIDTH-1:0] pending;
  logic                  pending_valid;
  logic [CW-1:0]         chan;
  logic [RATE_WIDTH-1:0] frame;
  logic [RATE_WIDTH-1:0] rate_m1;
  logic                  final_q;

  logic accept;
  logic beat_last;
  logic beat_final;
  logic apply_pend;
  logic out_hs;
  logic cfg_ok;

  assign s_axis_tready = (state == RUN) &&
                         (!m_axis_tvalid || m_axis_tready);
  assign accept     = s_axis_tvalid && s_axis_tready;
  assign rate_m1    = rate - RATE_WIDTH'(1);
  assign beat_last  = (chan == LAST_CHAN);
  assign beat_final = beat_last && (frame == rate_m1);
  assign out_hs     = m_axis_tvalid && m_axis_tready;
  assign integ_done = out_hs && final_q;
  assign busy       = (state != IDLE);
  assign cfg_ok     = cfg_update && (cfg_rate != '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending rate is consumed only when an integration starts fresh.
  always_comb begin
    state_nxt  = state;
    apply_pend = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt  = RUN;
          apply_pend = pending_valid;
        end
      end
      RUN: begin
        if (accept && beat_final) begin
          apply_pend = pending_valid;
          if (!enable) begin
            state_nxt = STOPPING;
          end
        end
      end
      STOPPING: begin
        if (!m_axis_tvalid || m_axis_tready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rate          <= RATE_WIDTH'(1);
      pending       <= '0;
      pending_valid <= 1'b0;
      cfg_error     <= 1'b0;
    end else begin
      cfg_error <= cfg_update && (cfg_rate == '0);
      if (apply_pend) begin
        rate <= pending;
      end
      if (cfg_ok) begin
        pending       <= cfg_rate;
        pending_valid <= 1'b1;
      end else if (apply_pend) begin
        pending_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      chan  <= '0;
      frame <= '0;
    end else if (state == IDLE && enable) begin
      chan  <= '0;
      frame <= '0;
    end else if (accept) begin
      chan <= beat_last ? '0 : chan + CW'(1);
      if (beat_last) begin
        frame <= beat_final ? '0 : frame + RATE_WIDTH'(1);
      end
    end
  end

  // final_q rides with tlast so integ_done lines up with the handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      final_q       <= 1'b0;
    end else if (accept) begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= beat_last;
      final_q       <= beat_final;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      integ_count <= '0;
    end else if (integ_done) begin
      integ_count <= integ_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_accumulator_frame_controller.sv
// Bench for axis_accumulator_frame_controller: vector table, directed
// corner sequences and a beat-index scoreboard model.
module tb_axis_accumulator_frame_controller;

  localparam int DW = 16;
  localparam int CH = 4;
  localparam int RW = 8;
  localparam int BIG = 1 << 30;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic [RW-1:0] cfg_rate = '0;
  logic          cfg_update = 1'b0;
  logic          cfg_error;
  logic [RW-1:0] rate;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          integ_done;
  logic          busy;
`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
  logic [31:0]   integ_count;
`endif

  axis_accumulator_frame_controller #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .RATE_WIDTH(RW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .enable       (enable),
    .cfg_rate     (cfg_rate),
    .cfg_update   (cfg_update),
    .cfg_error    (cfg_error),
    .rate         (rate),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .integ_done   (integ_done),
    .busy         (busy)
`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
    ,
    .integ_count  (integ_count)
`endif
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } exp_t;

  // Reference model: integrations end at cumulative beat indices.
  exp_t          sb[$];
  int            m_rate;
  int            m_pend;
  bit            m_pend_v;
  int            phase;
  int            beat_idx;
  int            integ_end;
  bit            err_exp;
  bit            acc_now;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            n_last;
  int            n_done;
  int            last_fin;
  longint        icnt;

  task automatic model_step();
    exp_t e;
    bit   hs;
    bit   fin;
    acc_now = 1'b0;
    if (areset) begin
      chk("reset_outputs",
          longint'({rate, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                    cfg_error, integ_done, busy, s_axis_tready}),
          longint'({8'd1, 22'd0}));
      m_rate = 1; m_pend = 0; m_pend_v = 0; phase = 0;
      beat_idx = 0; integ_end = 0; err_exp = 0;
      prev_stall = 0; icnt = 0;
      sb.delete();
      return;
    end
    chk("rate", longint'(rate), longint'(m_rate));
    chk("busy", longint'(busy), longint'(phase != 0));
    chk("cfg_error", longint'(cfg_error), longint'(err_exp));
`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
    chk("integ_count", longint'(integ_count), icnt);
`endif
    if (phase != 1) chk("tready_off", longint'(s_axis_tready), 0);
    if (prev_stall) begin
      chk("stall_valid", longint'(m_axis_tvalid), 1);
      chk("stall_data", longint'(m_axis_tdata), longint'(prev_data));
      chk("stall_last", longint'(m_axis_tlast), longint'(prev_last));
    end
    chk("queue_depth", longint'(sb.size()), longint'(m_axis_tvalid));
    hs = m_axis_tvalid && m_axis_tready;
    if (hs && sb.size() != 0) begin
      e = sb.pop_front();
      chk("tdata", longint'(m_axis_tdata), longint'(e.data));
      chk("tlast", longint'(m_axis_tlast), longint'(e.last));
      chk("integ_done", longint'(integ_done), longint'(e.fin));
      if (e.last) n_last++;
      if (e.fin) begin
        n_done++;
        icnt++;
        last_fin = int'(e.data);
      end
    end else begin
      chk("integ_done_quiet", longint'(integ_done), 0);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;

    err_exp = cfg_update && (cfg_rate == 0);
    acc_now = s_axis_tvalid && s_axis_tready;
    case (phase)
      0: if (enable) begin
        if (m_pend_v) begin m_rate = m_pend; m_pend_v = 0; end
        phase = 1;
        beat_idx = 0;
        integ_end = m_rate * CH - 1;
      end
      1: if (acc_now) begin
        fin = (beat_idx == integ_end);
        e.data = s_axis_tdata;
        e.last = ((beat_idx % CH) == CH - 1);
        e.fin  = fin;
        sb.push_back(e);
        if (fin) begin
          if (m_pend_v) begin m_rate = m_pend; m_pend_v = 0; end
          integ_end += m_rate * CH;
          if (!enable) phase = 2;
        end
        beat_idx++;
      end
      default: if (!m_axis_tvalid || m_axis_tready) phase = 0;
    endcase
    if (cfg_update && cfg_rate != 0) begin
      m_pend = int'(cfg_rate);
      m_pend_v = 1;
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1; enable = 0; cfg_update = 0; cfg_rate = 0;
    s_axis_tvalid = 0; s_axis_tdata = 0; m_axis_tready = 0;
    tick();
    tick();
    areset = 0;
    tick();
  endtask

  task automatic cfg(input int r);
    cfg_rate = RW'(r);
    cfg_update = 1;
    tick();
    cfg_update = 0;
  endtask

  task automatic send(input int n, input int base, input int vpct,
                      input int rpct, input bit rnd, input int upd_at,
                      input int upd_val, input int drop_at,
                      input int max_cyc, output int acc);
    int i = 0;
    bit upd_done = 0;
    for (int cyc = 0; cyc < max_cyc && i < n; cyc++) begin
      s_axis_tvalid = ($urandom_range(99) < vpct);
      s_axis_tdata  = rnd ? DW'($urandom) : DW'(base + i);
      m_axis_tready = ($urandom_range(99) < rpct);
      enable        = (i < drop_at);
      cfg_update    = (i == upd_at) && !upd_done;
      cfg_rate      = RW'(upd_val);
      if (cfg_update) upd_done = 1;
      tick();
      cfg_update = 0;
      if (acc_now) i++;
    end
    s_axis_tvalid = 0;
    acc = i;
  endtask

  task automatic drain();
    s_axis_tvalid = 0;
    m_axis_tready = 1;
    for (int k = 0; k < 20 && (sb.size() != 0 || m_axis_tvalid); k++)
      tick();
    chk("drain", longint'(sb.size()), 0);
  endtask

  typedef struct {
    int cfg;
    int n;
    int vpct;
    int rpct;
    bit rnd;
    int exp_last;
    int exp_done;
    int exp_rate;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int acc;
    int l0;
    int d0;
    tbl[0] = '{cfg: 0, n: 8,  vpct: 100, rpct: 100, rnd: 0,
               exp_last: 2,  exp_done: 2,  exp_rate: 1};
    tbl[1] = '{cfg: 3, n: 12, vpct: 100, rpct: 100, rnd: 0,
               exp_last: 3,  exp_done: 1,  exp_rate: 3};
    tbl[2] = '{cfg: 1, n: 64, vpct: 100, rpct: 50,  rnd: 1,
               exp_last: 16, exp_done: 16, exp_rate: 1};
    tbl[3] = '{cfg: 2, n: 16, vpct: 70,  rpct: 50,  rnd: 1,
               exp_last: 4,  exp_done: 2,  exp_rate: 2};
    tbl[4] = '{cfg: 4, n: 20, vpct: 60,  rpct: 80,  rnd: 1,
               exp_last: 5,  exp_done: 1,  exp_rate: 4};
    n_last = 0; n_done = 0; last_fin = -1;

    foreach (tbl[v]) begin
      do_reset();
      if (tbl[v].cfg != 0) cfg(tbl[v].cfg);
      l0 = n_last; d0 = n_done;
      send(tbl[v].n, 0, tbl[v].vpct, tbl[v].rpct, tbl[v].rnd,
           -1, 0, BIG, 2000, acc);
      chk($sformatf("vec%0d_accepted", v), acc, tbl[v].n);
      drain();
      chk($sformatf("vec%0d_tlasts", v), n_last - l0, tbl[v].exp_last);
      chk($sformatf("vec%0d_done", v), n_done - d0, tbl[v].exp_done);
      chk($sformatf("vec%0d_rate", v), longint'(rate), tbl[v].exp_rate);
    end

    // Rate change mid-integration waits for the boundary.
    do_reset();
    cfg(2);
    d0 = n_done;
    send(7, 0, 100, 100, 0, 2, 5, BIG, 100, acc);
    chk("chg_rate_hold", longint'(rate), 2);
    send(1, 7, 100, 100, 0, -1, 0, BIG, 100, acc);
    chk("chg_rate_switch", longint'(rate), 5);
    send(20, 8, 100, 100, 0, -1, 0, BIG, 200, acc);
    chk("chg_accepted", acc, 20);
    drain();
    chk("chg_done", n_done - d0, 2);
    chk("chg_last_final", last_fin, 27);

    // Stop mid-integration completes it; zero rate is rejected.
    do_reset();
    cfg(3);
    send(100, 0, 100, 100, 0, -1, 0, 5, 40, acc);
    chk("stop_accepted", acc, 12);
    chk("stop_busy", longint'(busy), 0);
    chk("stop_tready", longint'(s_axis_tready), 0);
    chk("stop_last_final", last_fin, 11);
    cfg(7);
    cfg_rate = 0;
    cfg_update = 1;
    tick();
    cfg_update = 0;
    chk("cfg_error_pulse", longint'(cfg_error), 1);
    tick();
    chk("cfg_error_clear", longint'(cfg_error), 0);
    send(4, 200, 100, 100, 0, -1, 0, BIG, 100, acc);
    chk("pending_kept", longint'(rate), 7);
    drain();

    // Reset mid-frame discards the partial frame.
    do_reset();
    send(2, 0, 100, 100, 0, -1, 0, BIG, 50, acc);
    s_axis_tvalid = 1;
    s_axis_tdata = 2;
    areset = 1;
    tick();
`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
    chk("count_reset", longint'(integ_count), 0);
`endif
    areset = 0;
    s_axis_tvalid = 0;
    enable = 0;
    tick();
    tick();
    l0 = n_last; d0 = n_done;
    send(4, 100, 100, 100, 0, -1, 0, BIG, 50, acc);
    drain();
    chk("rst_tlasts", n_last - l0, 1);
    chk("rst_done", n_done - d0, 1);
    chk("rst_last_final", last_fin, 103);
`ifdef AXIS_ACC_CTRL_INTEG_COUNT_EN
    chk("count_one", longint'(integ_count), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_accumulator_frame_controller.md
Name: axis_accumulator_frame_controller

Overview:
- Sequencer in front of axis_multichannel_accumulator.
- Takes a continuous, untagged multichannel sample stream and inserts tlast on every CHANNELS-th beat, marking the frame boundary the accumulator needs.
- Owns the accumulator's rate input: new rates are latched as pending and applied only at integration boundaries, so no integration ever mixes two rates.
- Provides start/stop sequencing; stop always completes the current integration before halting.

Parameters:
DATA_WIDTH, 16, sample width passed through unchanged
CHANNELS, 1024, beats per frame (>=2)
RATE_WIDTH, 8, width of rate/frame counters

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
enable  in  1  level; 1 = run, 0 = stop at next integration boundary
cfg_rate  in  RATE_WIDTH  requested frames per integration
cfg_update  in  1  one-cycle pulse; latch cfg_rate as pending
cfg_error  out  1  one-cycle pulse; cfg_update carried cfg_rate==0 (ignored)
rate  out  RATE_WIDTH  active rate, drives accumulator rate
s_axis_tdata  in  DATA_WIDTH  sample
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  sample ready
m_axis_tdata  out  DATA_WIDTH  registered sample
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last channel of frame
m_axis_tready  in  1  downstream ready
integ_done  out  1  one-cycle pulse when the final beat of an integration is accepted at the output
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async assert, released synchronously to aclk):
  - state=IDLE; rate=1; pending_valid=0.
  - chan=0, frame=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - cfg_error=0, integ_done=0, busy=0, s_axis_tready=0.
- FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - s_axis_tready=0.
  - If enable=1: go to RUN next cycle. If pending_valid=1, load rate from pending and clear pending_valid. Clear chan and frame.
- RUN:
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready).
  - Input accept = s_axis_tvalid && s_axis_tready. An accept loads the output register next cycle; latency is 1 cycle.
  - Each accepted beat carries m_axis_tlast = (chan==CHANNELS-1).
  - chan increments per accepted beat and wraps to 0 after CHANNELS-1.
  - frame increments on each tlast beat. When frame==rate-1 on a tlast beat, that beat is the integration-final beat; frame wraps to 0.
  - On an integration-final accept:
    - If pending_valid=1, load rate from pending and clear pending_valid, effective from the next beat.
    - If enable=0, go to STOPPING.
  - enable=0 mid-integration: keep running until the integration-final accept.
- STOPPING:
  - s_axis_tready=0.
  - Wait for the output register to drain (m_axis_tvalid=0, or m_axis_tready=1 on the last held beat), then go to IDLE.
- Output register:
  - m_axis_tdata/tlast are held stable while tvalid && !tready.
  - tvalid drops only on a handshake with no new accept.
- integ_done: pulses in the cycle the output handshake completes on an integration-final beat. Tracked via a registered flag alongside tlast.
- Configuration:
  - cfg_update with cfg_rate!=0: pending=cfg_rate, pending_valid=1. A later update overwrites an unapplied pending.
  - cfg_update with cfg_rate==0: pulse cfg_error, leave pending unchanged.
  - cfg_update in the same cycle as an integration-final accept: the old pending (if any) is applied to rate, and the new value is stored as pending.
  - In IDLE, pending is applied on entry to RUN.
- Width rule: frame is compared against rate-1 in RATE_WIDTH bits. rate is never 0.
- Reset mid-stream: everything returns to reset values; a partial frame is discarded (the accumulator is reset in the same domain).

Optional Feature:
- Macro: AXIS_ACC_CTRL_INTEG_COUNT_EN.
- Defined:
  - Adds output port integ_count, 32 bits, reset 0.
  - Increments on every integ_done pulse and wraps at 2^32-1 -> 0.
  - Holds its value through IDLE; cleared only by areset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan (CHANNELS=4, RATE_WIDTH=8 unless stated):
- Reset, then enable=1 with no cfg_update; stream 8 beats 0..7 with tready=1 -> rate=1; tlast on data 3 and 7; integ_done on both; first output one cycle after first input accept.
- cfg_update with rate=3 in IDLE, enable=1, stream 12 beats -> tlast on beats 3,7,11; single integ_done on beat 11; rate=3 from the first beat.
- Running with rate=2, cfg_update rate=5 at beat 2 -> rate stays 2 until beat 7 handshakes, becomes 5 afterwards; next integ_done at beat 27.
- Random m_axis_tready stalls (50%) over 64 beats -> no dropped or duplicated data; tdata/tlast stable while stalled; tlast every 4th beat.
- Drop enable at beat 5 with rate=3 -> beats accepted through beat 11 only; s_axis_tready=0 after that; busy falls after beat 11 handshakes; cfg_update with cfg_rate=0 -> cfg_error pulse, pending unchanged.
- Assert areset mid-frame at beat 2, release, re-enable -> outputs at reset values immediately; next stream starts with chan=0 (tlast on its 4th beat); with AXIS_ACC_CTRL_INTEG_COUNT_EN defined, integ_count=0 after reset and increments to 1 after the first integration.
